// File: rtl/instruction_cache.sv
// Direct-mapped read-only I-cache: 8 lines x 128 bits, 3-bit tag, fills whole blocks from instruction memory.
// Latency: hit serves the word combinationally in the request cycle; miss stalls 1 + N + 1 cycles.
// Backpressure: busywait stalls the CPU during a miss; the fill waits on mem_busywait before capturing the block.
module instruction_cache (
    input  logic         clock,
    input  logic         reset,
    input  logic         read,
    input  logic [9:0]   address,
    output logic [31:0]  instruction,
    output logic         busywait,
    output logic         mem_read,
    output logic [5:0]   mem_address,
    input  logic [127:0] mem_readinst,
    input  logic         mem_busywait
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [7:0]   valid;
    logic [2:0]   tag_mem  [8];
    logic [127:0] data_mem [8];

    logic [2:0]   miss_tag;
    logic [2:0]   miss_index;
    logic [127:0] fill_dat;
    logic [31:0]  inst_q;

    logic [2:0]   addr_tag;
    logic [2:0]   addr_index;
    logic [1:0]   addr_offset;
    logic [127:0] line_dat;
    logic [31:0]  line_word;
    logic         hit;
    logic         serve;
    logic         addr_unused;

    assign addr_tag    = address[9:7];
    assign addr_index  = address[6:4];
    assign addr_offset = address[3:2];
    assign addr_unused = ^address[1:0];

    assign line_dat  = data_mem[addr_index];
    assign line_word = line_dat[{addr_offset, 5'b0} +: 32];
    assign hit       = read && valid[addr_index] && (tag_mem[addr_index] == addr_tag);
    // Only IDLE serves words; a lookup that happens to hit mid-fill must not leak out.
    assign serve     = (state == IDLE) && hit;

    assign instruction = serve ? line_word : inst_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (read && !hit) next_state = MEM_READ;
            MEM_READ: if (!mem_busywait) next_state = UPDATE;
            UPDATE:   next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_read    = 1'b0;
        mem_address = 6'd0;
        busywait    = 1'b0;
        case (state)
            IDLE:     busywait = read && !hit;
            MEM_READ: begin
                mem_read    = 1'b1;
                mem_address = {miss_tag, miss_index};
                busywait    = 1'b1;
            end
            UPDATE:   busywait = 1'b1;
            default:  busywait = 1'b0;
        endcase
    end

    // Valid bits and miss bookkeeping are reset; a reset mid-fill leaves every line invalid.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid      <= 8'd0;
            miss_tag   <= 3'd0;
            miss_index <= 3'd0;
            inst_q     <= 32'd0;
        end else begin
            if (state == IDLE && read && !hit) begin
                miss_tag   <= addr_tag;
                miss_index <= addr_index;
            end
            if (state == UPDATE) begin
                valid[miss_index] <= 1'b1;
            end
            if (serve) begin
                inst_q <= line_word;
            end
        end
    end

    // Tag and data arrays carry no reset; valid gates every use of them.
    always_ff @(posedge clock) begin
        if (state == MEM_READ && !mem_busywait) begin
            fill_dat <= mem_readinst;
        end
        if (state == UPDATE) begin
            data_mem[miss_index] <= fill_dat;
            tag_mem[miss_index]  <= miss_tag;
        end
    end

endmodule
